// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU flag structure and add/sub opcode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef struct packed {
        logic cf;
        logic of;
        logic zf;
        logic nf;
    } alu_flags_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
// Module      : cla_slice
// Description : Combinational two-level carry-lookahead adder for one slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice #(
    parameter int SLICE = 16,
    parameter int BLOCK = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    localparam int NBLK = SLICE / BLOCK;

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_c;
    logic [NBLK-1:0]  w_bg;
    logic [NBLK-1:0]  w_bp;
    logic [NBLK:0]    w_bc;

    always_comb begin
        logic w_t;
        logic w_acc;
        w_t   = 1'b0;
        w_acc = 1'b0;
        w_g   = a & b;
        w_p   = a ^ b;
        w_bg  = '0;
        w_bp  = '0;
        w_bc  = '0;
        w_c   = '0;

        for (int j = 0; j < NBLK; j++) begin
            w_t   = 1'b0;
            w_acc = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                w_t   = w_g[j*BLOCK+i] | (w_p[j*BLOCK+i] & w_t);
                w_acc = w_acc & w_p[j*BLOCK+i];
            end
            w_bg[j] = w_t;
            w_bp[j] = w_acc;
        end

        // Each block carry is a flat sum of products over block G/P terms.
        for (int j = 0; j <= NBLK; j++) begin
            w_t = cin;
            for (int m = 0; m < j; m++) w_t = w_t & w_bp[m];
            w_acc = w_t;
            for (int i = 0; i < j; i++) begin
                w_t = w_bg[i];
                for (int m = i + 1; m < j; m++) w_t = w_t & w_bp[m];
                w_acc = w_acc | w_t;
            end
            w_bc[j] = w_acc;
        end

        for (int j = 0; j < NBLK; j++) begin
            for (int k = 0; k < BLOCK; k++) begin
                w_t = w_bc[j];
                for (int m = 0; m < k; m++) w_t = w_t & w_p[j*BLOCK+m];
                w_acc = w_t;
                for (int i = 0; i < k; i++) begin
                    w_t = w_g[j*BLOCK+i];
                    for (int m = i + 1; m < k; m++) w_t = w_t & w_p[j*BLOCK+m];
                    w_acc = w_acc | w_t;
                end
                w_c[j*BLOCK+k] = w_acc;
            end
        end

        s     = w_p ^ w_c;
        cout  = w_bc[NBLK];
        c_msb = w_c[SLICE-1];
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
// ============================================================================
// Module      : pipelined_cla_addsub
// Description : Skewed-pipeline carry-lookahead add/sub with valid/ready and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int BLOCK  = 4,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             nf
);

    localparam int SLICE = WIDTH / STAGES;

    if ((WIDTH % (STAGES * BLOCK)) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK");
    end

    // Level 0 holds the latched operands; level STAGES holds the finished result.
    logic [STAGES:0]  r_v;
    logic [STAGES:0]  r_c;
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES+1];
    logic             r_of;

    logic [SLICE-1:0] w_slice_s [STAGES];
    logic             w_cout    [STAGES];
    logic             w_cmsb    [STAGES];
    logic [WIDTH-1:0] w_merge   [STAGES];
    logic [WIDTH-1:0] w_bsel;
    logic             w_adv;
    alu_flags_t       w_flags;

    assign w_adv    = !r_v[STAGES] || out_ready;
    assign in_ready = w_adv && !rst;
    assign w_bsel   = (sub == ALU_OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(
            .SLICE (SLICE),
            .BLOCK (BLOCK)
        ) u_slice (
            .a     (r_a[k][k*SLICE +: SLICE]),
            .b     (r_b[k][k*SLICE +: SLICE]),
            .cin   (r_c[k]),
            .s     (w_slice_s[k]),
            .cout  (w_cout[k]),
            .c_msb (w_cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_merge[k]                   = r_s[k];
            w_merge[k][k*SLICE +: SLICE] = w_slice_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v  <= '0;
            r_c  <= '0;
            r_of <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) r_s[k] <= '0;
        end else if (w_adv) begin
            r_v    <= {r_v[STAGES-1:0], in_valid};
            r_a[0] <= a;
            r_b[0] <= w_bsel;
            r_c[0] <= sub;
            r_s[0] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k+1] <= w_merge[k];
                r_c[k+1] <= w_cout[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k+1] <= r_a[k];
                r_b[k+1] <= r_b[k];
            end
            r_of <= w_cout[STAGES-1] ^ w_cmsb[STAGES-1];
        end
    end

    always_comb begin
        w_flags.cf = r_c[STAGES];
        w_flags.of = r_of;
        w_flags.zf = (r_s[STAGES] == '0);
        w_flags.nf = r_s[STAGES][WIDTH-1];
    end

    assign out_valid = r_v[STAGES];
    assign sum       = r_s[STAGES];
    assign cf        = w_flags.cf;
    assign of        = w_flags.of;
    assign zf        = w_flags.zf;
    assign nf        = w_flags.nf;

endmodule

`default_nettype wire
